q15_mul_arbiter: RTL
====================

// Module: q15_mul_arbiter
// PURPOSE
//   Shares one pipelined Q1.15 multiplier among N_REQ requesters (gate-apply engines,
//   amplitude scalers) using round-robin arbitration. Accepts at most one operand pair
//   per cycle and returns each product exactly LAT cycles later, tagged with the
//   requester ID. Sits between the qubit-gate datapath lanes and the single DSP multiplier.
// PARAMETERS
//   N_REQ  4  number of requesters (>=2)
//   LAT    2  cycles from accept to rsp_valid (>=1); internal multiply pipeline depth
//   IDW    $clog2(N_REQ)  width of requester ID (derived, not overridden)
// PORTS
//   clk        in   1            rising-edge clock
//   rst_n      in   1            asynchronous reset, active low
//   hold       in   1            1 = grant nothing this cycle; pipeline keeps draining
//   req_valid  in   N_REQ        per-requester operand valid
//   req_ready  out  N_REQ        per-requester accept (one-hot or zero)
//   req_a      in   N_REQ*16     operand A, signed Q1.15, requester i at [16i+:16]
//   req_b      in   N_REQ*16     operand B, signed Q1.15, requester i at [16i+:16]
//   rsp_valid  out  1            result valid (single cycle, no backpressure)
//   rsp_id     out  IDW          requester index owning the result
//   rsp_data   out  16           signed Q1.15 product
//   rsp_sat    out  1            1 = rsp_data was saturated
//   idle       out  1            1 = no accepted operation in flight
// BEHAVIOUR
//   Reset: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_sat=0, all pipeline valids=0,
//     RR pointer=0, idle=1. req_ready is combinational and therefore 0 while rst_n=0.
//   Arbitration: combinational. Search from RR pointer upward, wrapping mod N_REQ; the
//     first i with req_valid[i]=1 gets req_ready[i]=1. No grant if hold=1 or no
//     request. req_ready may depend on req_valid; requesters hold valid and operands
//     stable until ready is seen.
//   Transfer: valid&ready on lane i in cycle t. RR pointer <= (i+1) mod N_REQ at the
//     next edge; pointer unchanged on cycles with no transfer. Wrap from N_REQ-1 to 0.
//   Latency: result of the cycle-t transfer has rsp_valid=1 in cycle t+LAT, with
//     rsp_id=i. Throughput 1/cycle; back-to-back transfers give back-to-back rsp_valid.
//     Results leave in accept order. Consumers must sink every rsp_valid cycle.
//   Arithmetic: p = a*b as 32-bit signed; r = p >>> 15 (arithmetic shift, truncates
//     toward -inf). If r > 32767 (only 0x8000*0x8000) then rsp_data=0x7FFF, rsp_sat=1;
//     otherwise rsp_data=r[15:0], rsp_sat=0. No other rounding.
//   rsp_id, rsp_data and rsp_sat hold their last values when rsp_valid=0.
//   idle = no pipeline stage valid (combinational from the stage valid bits). The current
//     cycle's transfer is not counted until the next edge.
//   hold asserted mid-stream: in-flight results still emerge on schedule; the pointer
//     is frozen.
//   Reset mid-operation: all in-flight results are discarded. No rsp_valid occurs after
//     rst_n rises until a new transfer completes LAT cycles later.
//   Simultaneous requests: exactly one grant per cycle. A requester that holds valid
//     continuously waits at most N_REQ-1 cycles for a grant (no starvation).
// TESTING
//   1 Single: lane 2 a=0x5A82 b=0x5A82 -> 2 cycles later rsp_valid=1, id=2,
//     data=0x3FFF, sat=0; idle returns to 1.
//   2 Arithmetic: 0x7FFF*0x7FFF->0x7FFE; 0xC000*0x4000->0xE000; 0xFFFF*0x0001->0xFFFF;
//     0x8000*0x8000->0x7FFF with sat=1.
//   3 Fairness: all 4 lanes hold valid for 8 cycles from pointer 0 -> grants
//     0,1,2,3,0,1,2,3; rsp_id follows the same sequence, offset by LAT.
//   4 Hold: all lanes valid, hold=1 for 3 cycles after 2 grants -> no req_ready and
//     pointer frozen; the 2 in-flight results still appear; resume grants lane 2.
//   5 Reset: drop rst_n with 2 ops in flight -> outputs 0 immediately; after release
//     no rsp_valid for LAT+2 cycles with no requests, and the pointer restarts at lane 0.
//   6 Sweep: random operands and valids for 10k cycles, LAT=1 and LAT=3 -> every
//     transfer produces exactly one matching result, checked against a model.

Source files
------------

// File: rtl/q15_mul_arbiter.sv
// Round-robin front end sharing one pipelined saturating Q1.15 multiplier among N_REQ
// requesters; each product is returned LAT cycles after acceptance, tagged with its requester ID.
module q15_mul_arbiter #(
    parameter int N_REQ = 4,
    parameter int LAT   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       hold,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*16-1:0]        req_a,
    input  logic [N_REQ*16-1:0]        req_b,
    output logic                       rsp_valid,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [15:0]                rsp_data,
    output logic                       rsp_sat,
    output logic                       idle
);
    localparam int IDW = $clog2(N_REQ);
    localparam logic [IDW:0]   N_REQ_W = (IDW+1)'(N_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

    // Only 0x8000*0x8000 can exceed the Q1.15 range after the floor shift.
    function automatic logic [16:0] q15_mul_sat(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] a_ext;
        logic signed [31:0] b_ext;
        logic signed [31:0] prod;
        logic signed [31:0] shr;
        a_ext = {{16{a[15]}}, a};
        b_ext = {{16{b[15]}}, b};
        prod  = a_ext * b_ext;
        shr   = prod >>> 15;
        if (shr > 32'sd32767) begin
            q15_mul_sat = {1'b1, 16'h7FFF};
        end else begin
            q15_mul_sat = {1'b0, shr[15:0]};
        end
    endfunction

    logic [IDW-1:0]   rr_ptr_r;
    logic [LAT-1:0]   valid_r;
    logic [IDW-1:0]   id_r   [LAT];
    logic [15:0]      data_r [LAT];
    logic             sat_r  [LAT];

    logic [N_REQ-1:0] grant_s;
    logic [IDW-1:0]   gnt_id_s;
    logic             gnt_found_s;
    logic [IDW:0]     idx_s;
    logic             hit_s;
    logic [15:0]      op_a_s;
    logic [15:0]      op_b_s;
    logic [16:0]      mul_s;
    logic [IDW-1:0]   ptr_nxt_s;

    // Round-robin search from the pointer; nothing is granted under hold or reset.
    always_comb begin
        grant_s     = '0;
        gnt_id_s    = '0;
        gnt_found_s = 1'b0;
        idx_s       = '0;
        hit_s       = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s = {1'b0, rr_ptr_r} + (IDW+1)'(k);
            idx_s = (idx_s >= N_REQ_W) ? (idx_s - N_REQ_W) : idx_s;
            hit_s = rst_n & ~hold & ~gnt_found_s & req_valid[idx_s[IDW-1:0]];
            grant_s[idx_s[IDW-1:0]] = grant_s[idx_s[IDW-1:0]] | hit_s;
            gnt_id_s    = hit_s ? idx_s[IDW-1:0] : gnt_id_s;
            gnt_found_s = gnt_found_s | hit_s;
        end
    end

    assign req_ready = grant_s;
    assign op_a_s    = req_a[16*gnt_id_s +: 16];
    assign op_b_s    = req_b[16*gnt_id_s +: 16];
    assign mul_s     = q15_mul_sat(op_a_s, op_b_s);
    assign ptr_nxt_s = (gnt_id_s == LAST_ID) ? '0 : (gnt_id_s + IDW'(1));

    // Result pipeline; payload stages load only behind a valid so the outputs hold between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
            valid_r  <= '0;
            for (int k = 0; k < LAT; k++) begin
                id_r[k]   <= '0;
                data_r[k] <= 16'h0000;
                sat_r[k]  <= 1'b0;
            end
        end else begin
            valid_r[0] <= gnt_found_s;
            if (gnt_found_s) begin
                id_r[0]   <= gnt_id_s;
                data_r[0] <= mul_s[15:0];
                sat_r[0]  <= mul_s[16];
                rr_ptr_r  <= ptr_nxt_s;
            end
            for (int k = 1; k < LAT; k++) begin
                valid_r[k] <= valid_r[k-1];
                if (valid_r[k-1]) begin
                    id_r[k]   <= id_r[k-1];
                    data_r[k] <= data_r[k-1];
                    sat_r[k]  <= sat_r[k-1];
                end
            end
        end
    end

    assign rsp_valid = valid_r[LAT-1];
    assign rsp_id    = id_r[LAT-1];
    assign rsp_data  = data_r[LAT-1];
    assign rsp_sat   = sat_r[LAT-1];
    assign idle      = ~|valid_r;

endmodule
